// File: rtl/cnn_mac_pkg.sv
// rtl/cnn_mac_pkg.sv - default widths, saturation bounds and signed types for the MAC/requant lane
package cnn_mac_pkg;

    localparam int PROD_WIDTH = 24;
    localparam int ACC_WIDTH  = 32;
    localparam int OUT_WIDTH  = 16;

    localparam int SAT_MAX = (1 << (OUT_WIDTH - 1)) - 1;
    localparam int SAT_MIN = -(1 << (OUT_WIDTH - 1));

    typedef logic signed [PROD_WIDTH-1:0] prod_t;
    typedef logic signed [ACC_WIDTH-1:0]  acc_t;
    typedef logic signed [OUT_WIDTH-1:0]  act_t;

endpackage

// File: rtl/cnn_requant_sat.sv
// rtl/cnn_requant_sat.sv - arithmetic shift, saturate and optional ReLU (CNN_MAC_RELU_EN)
module cnn_requant_sat
    import cnn_mac_pkg::*;
#(
    parameter int ACC_WIDTH = cnn_mac_pkg::ACC_WIDTH,
    parameter int OUT_WIDTH = cnn_mac_pkg::OUT_WIDTH,
    parameter int SHIFT     = 8
) (
    input  logic signed [ACC_WIDTH-1:0] final_sum,
    output logic signed [OUT_WIDTH-1:0] result
);

    // Bounds are held at accumulator width so the comparison sees the full shifted value.
    localparam logic signed [ACC_WIDTH-1:0] HI = ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] LO = ~HI;

    logic signed [ACC_WIDTH-1:0] shifted;
    logic signed [OUT_WIDTH-1:0] sat;

    always_comb begin
        shifted = final_sum >>> SHIFT;
        if (shifted > HI) begin
            sat = HI[OUT_WIDTH-1:0];
        end else if (shifted < LO) begin
            sat = LO[OUT_WIDTH-1:0];
        end else begin
            sat = shifted[OUT_WIDTH-1:0];
        end
`ifdef CNN_MAC_RELU_EN
        result = sat[OUT_WIDTH-1] ? '0 : sat;
`else
        result = sat;
`endif
    end

endmodule

// File: rtl/cnn_mac_requant.sv
// rtl/cnn_mac_requant.sv - windowed product accumulator with bias, requant and valid/ready output
module cnn_mac_requant
    import cnn_mac_pkg::*;
#(
    parameter int PROD_WIDTH = cnn_mac_pkg::PROD_WIDTH,
    parameter int ACC_WIDTH  = cnn_mac_pkg::ACC_WIDTH,
    parameter int OUT_WIDTH  = cnn_mac_pkg::OUT_WIDTH,
    parameter int KERNEL_LEN = 25,
    parameter int SHIFT      = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic signed [PROD_WIDTH-1:0] in_data,
    input  logic signed [ACC_WIDTH-1:0]  bias,
    output logic                         ce_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         busy
);

    localparam int CNT_W = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(KERNEL_LEN - 1);

    logic [CNT_W-1:0]            cnt;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] ext;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [OUT_WIDTH-1:0] requant;
    logic                        accept;
    logic                        is_last;

    // Stalling the multiplier is the only backpressure path, so ce must react to out_ready combinationally.
    assign ce_out  = ~out_valid | out_ready;
    assign accept  = in_valid & ce_out;
    assign is_last = (cnt == LAST);
    assign ext     = ACC_WIDTH'(in_data);
    assign sum     = ((cnt == '0) ? bias : acc) + ext;
    assign busy    = (cnt != '0);

    cnn_requant_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_requant (
        .final_sum (sum),
        .result    (requant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                acc <= sum;
                if (is_last) begin
                    cnt       <= '0;
                    out_valid <= 1'b1;
                    out_data  <= requant;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
